// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - DC32 one-second time base and button-driven BCD time-set FSM
// Freezes the counter chain while hours/minutes are edited, then issues a one-cycle load.
module clock_set_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [1:0] cur_hour_ten,
  input  logic [3:0] cur_hour_unit,
  input  logic [2:0] cur_min_ten,
  input  logic [3:0] cur_min_unit,
  output logic       tick,
  output logic       load,
  output logic [1:0] ld_hour_ten,
  output logic [3:0] ld_hour_unit,
  output logic [2:0] ld_min_ten,
  output logic [3:0] ld_min_unit,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;

  logic [1:0] edit_hour_ten;
  logic [3:0] edit_hour_unit;
  logic [2:0] edit_min_ten;
  logic [3:0] edit_min_unit;

  logic [1:0] hour_inc_ten;
  logic [3:0] hour_inc_unit;
  logic [2:0] min_inc_ten;
  logic [3:0] min_inc_unit;
  logic       hour_ok;
  logic       min_ok;

  logic enter_edit;
  logic do_hour_inc;
  logic do_min_inc;

  // mode_btn takes priority: an inc in the same cycle is dropped.
  assign enter_edit  = (state == RUN) && mode_btn;
  assign do_hour_inc = (state == SET_HOUR) && !mode_btn && inc_btn;
  assign do_min_inc  = (state == SET_MIN) && !mode_btn && inc_btn;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mode_btn) state_next = SET_HOUR;
      SET_HOUR: if (mode_btn) state_next = SET_MIN;
      SET_MIN:  if (mode_btn) state_next = COMMIT;
      COMMIT:   state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Output decode straight from registered state and cnt
  always_comb begin
    tick  = 1'b0;
    load  = 1'b0;
    blink = 1'b0;
    case (state)
      RUN:      tick  = (cnt == CNT_MAX);
      SET_HOUR: blink = (cnt < CNT_HALF);
      SET_MIN:  blink = (cnt < CNT_HALF);
      COMMIT:   load  = 1'b1;
      default: begin
        tick  = 1'b0;
        load  = 1'b0;
        blink = 1'b0;
      end
    endcase
  end

  assign mode = state;

  // Prescaler restarts on entering the editor and on leaving COMMIT so the
  // first post-commit second is a full TICK_DIV cycles long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enter_edit || (state == COMMIT)) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Hour 00..23; anything out of range or non-BCD falls to 00.
  always_comb begin
    hour_inc_ten  = 2'd0;
    hour_inc_unit = 4'd0;
    hour_ok = ((edit_hour_ten < 2'd2) && (edit_hour_unit <= 4'd9)) ||
              ((edit_hour_ten == 2'd2) && (edit_hour_unit < 4'd3));
    if (hour_ok) begin
      if (edit_hour_unit == 4'd9) begin
        hour_inc_ten  = edit_hour_ten + 2'd1;
        hour_inc_unit = 4'd0;
      end else begin
        hour_inc_ten  = edit_hour_ten;
        hour_inc_unit = edit_hour_unit + 4'd1;
      end
    end
  end

  // Minute 00..59; never carries into the hour.
  always_comb begin
    min_inc_ten  = 3'd0;
    min_inc_unit = 4'd0;
    min_ok = ((edit_min_ten < 3'd5) && (edit_min_unit <= 4'd9)) ||
             ((edit_min_ten == 3'd5) && (edit_min_unit < 4'd9));
    if (min_ok) begin
      if (edit_min_unit == 4'd9) begin
        min_inc_ten  = edit_min_ten + 3'd1;
        min_inc_unit = 4'd0;
      end else begin
        min_inc_ten  = edit_min_ten;
        min_inc_unit = edit_min_unit + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_hour_ten  <= 2'd0;
      edit_hour_unit <= 4'd0;
      edit_min_ten   <= 3'd0;
      edit_min_unit  <= 4'd0;
    end else if (enter_edit) begin
      edit_hour_ten  <= cur_hour_ten;
      edit_hour_unit <= cur_hour_unit;
      edit_min_ten   <= cur_min_ten;
      edit_min_unit  <= cur_min_unit;
    end else if (do_hour_inc) begin
      edit_hour_ten  <= hour_inc_ten;
      edit_hour_unit <= hour_inc_unit;
    end else if (do_min_inc) begin
      edit_min_ten   <= min_inc_ten;
      edit_min_unit  <= min_inc_unit;
    end
  end

  assign ld_hour_ten  = edit_hour_ten;
  assign ld_hour_unit = edit_hour_unit;
  assign ld_min_ten   = edit_min_ten;
  assign ld_min_unit  = edit_min_unit;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed-vector bench for clock_set_ctrl at TICK_DIV = 4
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [1:0] cur_hour_ten = 2'd0;
  logic [3:0] cur_hour_unit = 4'd0;
  logic [2:0] cur_min_ten = 3'd0;
  logic [3:0] cur_min_unit = 4'd0;
  logic       tick;
  logic       load;
  logic [1:0] ld_hour_ten;
  logic [3:0] ld_hour_unit;
  logic [2:0] ld_min_ten;
  logic [3:0] ld_min_unit;
  logic [1:0] mode;
  logic       blink;
  logic [12:0] ld_all;

  int vectors = 0;
  int miscompares = 0;

  clock_set_ctrl #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_btn     (mode_btn),
    .inc_btn      (inc_btn),
    .cur_hour_ten (cur_hour_ten),
    .cur_hour_unit(cur_hour_unit),
    .cur_min_ten  (cur_min_ten),
    .cur_min_unit (cur_min_unit),
    .tick         (tick),
    .load         (load),
    .ld_hour_ten  (ld_hour_ten),
    .ld_hour_unit (ld_hour_unit),
    .ld_min_ten   (ld_min_ten),
    .ld_min_unit  (ld_min_unit),
    .mode         (mode),
    .blink        (blink)
  );

  assign ld_all = {ld_hour_ten, ld_hour_unit, ld_min_ten, ld_min_unit};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
  endtask

  task automatic press_inc();
    inc_btn = 1'b1;
    step();
    inc_btn = 1'b0;
  endtask

  task automatic set_cur(input logic [1:0] ht, input logic [3:0] hu,
                         input logic [2:0] mt, input logic [3:0] mu);
    cur_hour_ten  = ht;
    cur_hour_unit = hu;
    cur_min_ten   = mt;
    cur_min_unit  = mu;
  endtask

  initial begin
    // Scenario 1: reset values, then free-running ticks every 4th cycle
    step();
    step();
    check("rst_mode", mode, 2'd0);
    check("rst_ld", ld_all, 13'd0);
    check("rst_outs", {tick, load, blink}, 3'b000);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("s1_tick", tick, (k % 4 == 3));
      check("s1_idle", {load, blink, mode}, 4'd0);
    end

    // Scenario 2: 09:59 -> 10:59 -> 10:00 -> commit, then full-length first second
    set_cur(2'd0, 4'd9, 3'd5, 4'd9);
    press_mode();
    check("s2_mode_sh", mode, 2'd1);
    check("s2_cap", ld_all, {2'd0, 4'd9, 3'd5, 4'd9});
    press_inc();
    check("s2_hour_carry", ld_all, {2'd1, 4'd0, 3'd5, 4'd9});
    press_mode();
    check("s2_mode_sm", mode, 2'd2);
    press_inc();
    check("s2_min_wrap", ld_all, {2'd1, 4'd0, 3'd0, 4'd0});
    press_mode();
    check("s2_mode_commit", mode, 2'd3);
    check("s2_load", load, 1'b1);
    check("s2_tick_commit", tick, 1'b0);
    check("s2_ld_commit", ld_all, {2'd1, 4'd0, 3'd0, 4'd0});
    step();
    check("s2_mode_run", mode, 2'd0);
    check("s2_load_off", load, 1'b0);
    check("s2_ld_hold", ld_all, {2'd1, 4'd0, 3'd0, 4'd0});
    for (int k = 1; k <= 3; k++) begin
      step();
      check("s2_post_tick", tick, (k == 3));
    end

    // Scenario 3: hour 22 -> 23 -> 00, minute 58 -> 59 -> 00
    set_cur(2'd2, 4'd2, 3'd5, 4'd8);
    press_mode();
    check("s3_cap", ld_all, {2'd2, 4'd2, 3'd5, 4'd8});
    press_inc();
    check("s3_h23", ld_all, {2'd2, 4'd3, 3'd5, 4'd8});
    press_inc();
    check("s3_h00", ld_all, {2'd0, 4'd0, 3'd5, 4'd8});
    press_mode();
    press_inc();
    check("s3_m59", ld_all, {2'd0, 4'd0, 3'd5, 4'd9});
    press_inc();
    check("s3_m00", ld_all, {2'd0, 4'd0, 3'd0, 4'd0});
    press_mode();
    check("s3_load", load, 1'b1);
    step();
    check("s3_run", mode, 2'd0);

    // Scenario 4: simultaneous mode+inc in SET_MIN goes to COMMIT, minute kept
    set_cur(2'd1, 4'd2, 3'd3, 4'd4);
    press_mode();
    press_mode();
    mode_btn = 1'b1;
    inc_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    check("s4_mode", mode, 2'd3);
    check("s4_ld", ld_all, {2'd1, 4'd2, 3'd3, 4'd4});
    step();
    check("s4_run", mode, 2'd0);

    // Scenario 5: reset in SET_MIN with pending edits
    set_cur(2'd0, 4'd5, 3'd0, 4'd7);
    press_mode();
    press_inc();
    press_mode();
    press_inc();
    check("s5_pending", ld_all, {2'd0, 4'd6, 3'd0, 4'd8});
    reset = 1'b1;
    #1;
    check("s5_rst_mode", mode, 2'd0);
    check("s5_rst_ld", ld_all, 13'd0);
    check("s5_rst_load", load, 1'b0);
    step();
    check("s5_rst_hold", {load, tick, mode}, 4'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("s5_tick", tick, (k % 4 == 3));
      check("s5_noload", {load, mode}, 3'd0);
    end

    // Scenario 6: illegal hour 27 and non-BCD minute 3B, blink cadence, frozen ticks
    set_cur(2'd2, 4'd7, 3'd3, 4'd11);
    press_mode();
    check("s6_cap", ld_all, {2'd2, 4'd7, 3'd3, 4'd11});
    check("s6_b0", {blink, tick}, 2'b10);
    step();
    check("s6_b1", {blink, tick}, 2'b10);
    step();
    check("s6_b2", {blink, tick}, 2'b00);
    step();
    check("s6_b3", {blink, tick}, 2'b00);
    step();
    check("s6_b4", {blink, tick}, 2'b10);
    press_inc();
    check("s6_h_illegal", ld_all, {2'd0, 4'd0, 3'd3, 4'd11});
    check("s6_b5", {blink, tick}, 2'b10);
    press_mode();
    check("s6_sm_b", {blink, tick, mode}, 4'b0010);
    press_inc();
    check("s6_m_illegal", ld_all, 13'd0);
    check("s6_sm_b3", {blink, tick}, 2'b00);
    step();
    check("s6_sm_b0", {blink, tick}, 2'b10);
    press_mode();
    check("s6_commit", {load, blink, tick, mode}, 5'b10011);
    step();
    check("s6_run", {load, blink, mode}, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
